// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  // Values of the runtime ovl input
  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  // Legal parameter ranges
  localparam int W_MIN  = 2;
  localparam int W_MAX  = 32;
  localparam int CW_MIN = 1;
  localparam int CW_MAX = 16;

  // Pattern compare: equal on every bit position not marked don't-care in m.
  // Callers zero-extend to W_MAX; the zero upper bits of a and b always agree.
  function automatic logic masked_eq(input logic [W_MAX-1:0] a,
                                     input logic [W_MAX-1:0] b,
                                     input logic [W_MAX-1:0] m);
    return ((a ^ b) & ~m) == '0;
  endfunction

  // True when the pattern length and counter width are inside the supported range
  function automatic bit params_ok(input int w, input int cw);
    return (w >= W_MIN) && (w <= W_MAX) && (cw >= CW_MIN) && (cw <= CW_MAX);
  endfunction

endpackage

// File: rtl/seq_hist.sv
// History holder: W-bit serial shift register plus a saturating fill count.
// Presents the next-state history so the parent can compare in the same cycle.
module seq_hist #(
  parameter int W   = 4,
  parameter int FCW = $clog2(W + 1)
) (
  input  logic           c,
  input  logic           r,
  input  logic           en,
  input  logic           x,
  input  logic           clr,
  input  logic           rst_fill,
  output logic [W-1:0]   nsr,
  output logic [FCW-1:0] nfc,
  output logic           fill
);

  localparam logic [FCW-1:0] FC_FULL = FCW'(W);

  logic [W-1:0]   sr;
  logic [FCW-1:0] fc;

  // Next history and fill count if the current bit is accepted
  always_comb begin
    // NOTE: every output is assigned on every path, so no latch is inferred.
    nsr = {sr[W-2:0], x};
    nfc = (fc == FC_FULL) ? fc : fc + 1'b1;
  end

  // History, fill count and registered fill flag; reset beats clear beats shift
  always_ff @(posedge c) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!r) begin
      sr   <= '0;
      fc   <= '0;
      fill <= 1'b0;
    end else if (clr) begin
      sr   <= '0;
      fc   <= '0;
      fill <= 1'b0;
    end else if (en) begin
      sr <= nsr;
      if (rst_fill) begin
        fc   <= '0;
        fill <= 1'b0;
      end else begin
        fc   <= nfc;
        fill <= (nfc == FC_FULL);
      end
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector: programmable pattern with don't-care
// mask, overlapping or non-overlapping matching, registered match pulse and a
// saturating match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int W       = 4,
  parameter int CW      = 8,
  parameter int OVERLAP = 1
) (
  input  logic          c,
  input  logic          r,
  input  logic          en,
  input  logic          x,
  input  logic          clr,
  input  logic          ovl,
  input  logic [W-1:0]  pat,
  input  logic [W-1:0]  msk,
  output logic          y,
  output logic [CW-1:0] cnt,
  output logic          sat,
  output logic          fill
);

  localparam int FCW = $clog2(W + 1);

  // Reject unsupported configurations at elaboration time
  if (!params_ok(W, CW) || (OVERLAP != 0 && OVERLAP != 1)) begin : g_param_err
    $error("seq_det_param: W must be 2..32, CW 1..16, OVERLAP 0 or 1");
  end

  logic [W-1:0]   nsr;
  logic [FCW-1:0] nfc;
  logic           hit;
  logic           rst_fill;
  logic [CW-1:0]  cnt_inc;

  seq_hist #(.W(W), .FCW(FCW)) u_hist (
    .c        (c),
    .r        (r),
    .en       (en),
    .x        (x),
    .clr      (clr),
    .rst_fill (rst_fill),
    .nsr      (nsr),
    .nfc      (nfc),
    .fill     (fill)
  );

  // Match on the history including this cycle's bit; pat, msk and ovl sampled now
  always_comb begin
    hit      = en && !clr && (nfc == FCW'(W))
               && masked_eq(W_MAX'(nsr), W_MAX'(pat), W_MAX'(msk));
    rst_fill = hit && (ovl == MODE_NOVL);
    cnt_inc  = cnt + 1'b1;
  end

  // Registered match pulse and saturating counter with sticky saturation flag
  always_ff @(posedge c) begin
    if (!r) begin
      y   <= 1'b0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      y   <= 1'b0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      y <= hit;
      if (hit && !sat) begin
        cnt <= cnt_inc;
        sat <= &cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Randomised and directed bench for seq_det_param with a scoreboard against a
// bit-queue reference model.
module tb_seq_det_param;

  localparam int W       = 4;
  localparam int CW      = 3;
  localparam int OVERLAP = 1;
  localparam int CMAX    = (1 << CW) - 1;

  logic          c = 1'b0;
  logic          r, en, x, clr, ovl;
  logic [W-1:0]  pat, msk;
  logic          y;
  logic [CW-1:0] cnt;
  logic          sat, fill;

  seq_det_param #(.W(W), .CW(CW), .OVERLAP(OVERLAP)) dut (
    .c    (c),
    .r    (r),
    .en   (en),
    .x    (x),
    .clr  (clr),
    .ovl  (ovl),
    .pat  (pat),
    .msk  (msk),
    .y    (y),
    .cnt  (cnt),
    .sat  (sat),
    .fill (fill)
  );

  always #5 c = ~c;

  typedef struct {
    logic y;
    int   cnt;
    logic sat;
    logic fill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: received bits since reset/clear, fresh bits since restart
  bit hist[$];
  int fresh  = 0;
  int mcount = 0;

  bit s1 [7] = '{1, 0, 1, 1, 0, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Last W received bits against pat, ignoring don't-care positions
  function automatic bit pattern_hits();
    for (int i = 0; i < W; i++) begin
      if (!msk[i] && (hist[hist.size() - 1 - i] != pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply one cycle of stimulus, predict the outputs after the edge, queue them
  task automatic step(input bit en_i, input bit x_i, input bit clr_i, input bit r_i);
    exp_t e;
    en  = en_i;
    x   = x_i;
    clr = clr_i;
    r   = r_i;
    e.y = 1'b0;
    if (!r_i || clr_i) begin
      hist.delete();
      fresh  = 0;
      mcount = 0;
    end else if (en_i) begin
      hist.push_back(x_i);
      if (hist.size() > W) void'(hist.pop_front());
      fresh = (fresh < W) ? fresh + 1 : W;
      if (fresh == W && pattern_hits()) begin
        e.y = 1'b1;
        if (mcount < CMAX) mcount++;
        if (!ovl) fresh = 0;
      end
    end
    e.cnt  = mcount;
    e.sat  = (mcount == CMAX);
    e.fill = (fresh == W);
    @(posedge c);
    sb_q.push_back(e);
    @(negedge c);
  endtask

  // Monitor: every registered output is compared once per clock, away from the edge
  always @(negedge c) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("y",    32'(y),    32'(e.y));
      check("cnt",  32'(cnt),  32'(e.cnt));
      check("sat",  32'(sat),  32'(e.sat));
      check("fill", 32'(fill), 32'(e.fill));
    end
  end

  initial begin
    en = 0; x = 0; clr = 0; r = 0; ovl = 1'(OVERLAP); pat = '0; msk = '0;
    @(negedge c);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("reset_cnt", 32'(cnt), 0);

    // Overlapping detection of 1011 in 1011011
    ovl = 1; pat = 4'b1011; msk = 4'b0000;
    for (int i = 0; i < 7; i++) step(1, s1[i], 0, 1);
    check("ovl_cnt", 32'(cnt), 2);
    check("ovl_fill", 32'(fill), 1);

    // Same stream, non-overlapping
    step(0, 0, 1, 1);
    ovl = 0;
    for (int i = 0; i < 7; i++) step(1, s1[i], 0, 1);
    check("novl_cnt", 32'(cnt), 1);
    check("novl_fill", 32'(fill), 0);

    // Don't-care bit with idle gaps between bits
    step(0, 0, 1, 1);
    ovl = 1; pat = 4'b1011; msk = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1);
      step(0, 0, 0, 1);
    end
    check("gap_cnt", 32'(cnt), 1);

    // Saturation: all don't-care, hit on every bit once full
    step(0, 0, 1, 1);
    msk = 4'b1111;
    for (int i = 0; i < 4 + CMAX + 2; i++) step(1, 1'($urandom), 0, 1);
    check("sat_cnt", 32'(cnt), CMAX);
    check("sat_flag", 32'(sat), 1);

    // Reset mid-stream, including en in the reset cycle
    step(0, 0, 1, 1);
    msk = 4'b0000; pat = 4'b1011;
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_fill", 32'(fill), 0);

    // Clear with simultaneous en after a match
    for (int i = 0; i < 4; i++) step(1, s1[i], 0, 1);
    step(1, 1, 1, 1);
    check("clr_cnt", 32'(cnt), 0);
    step(1, 1, 0, 1);

    // Pattern written in the same cycle as the completing bit
    step(0, 0, 1, 1);
    pat = 4'b0000;
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    pat = 4'b1011;
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    check("pat_same_cnt", 32'(cnt), 1);

    // Pattern written one cycle too late
    step(0, 0, 1, 1);
    pat = 4'b0000;
    for (int i = 0; i < 4; i++) step(1, s1[i], 0, 1);
    pat = 4'b1011;
    step(0, 0, 0, 1);
    check("pat_late_cnt", 32'(cnt), 0);

    // Random traffic with occasional mode/pattern changes, clears and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) ovl = 1'($urandom);
      if ($urandom_range(29) == 0) begin
        pat = W'($urandom);
        msk = ($urandom_range(2) == 0) ? W'($urandom) : '0;
      end
      step(($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(299) == 0), ($urandom_range(499) != 0));
    end

    @(posedge c);
    #1;
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
